trap_ctrl: RTL and testbench

- Next-generation pipeline/trap controller for the RV32IM core. Sits beside the CSR file.
- Owns the fetch PC, per-stage stalls and flush, and takes synchronous exceptions, prioritised machine interrupts and MRET.
- Adds beyond the previous controller: parametrised local interrupt lines (mip/mie bits 16+), a multi-cycle flush FSM, an MRET return path, and a registered trap record (cause/value/epc) with a one-cycle commit pulse to the CSR file.

---
 rtl/trap_ctrl_pkg.sv | 50 +++++
 rtl/trap_ctrl_irq_prio_enc.sv | 31 +++
 rtl/trap_ctrl.sv | 167 ++++++++++++++++
 tb/tb_trap_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the pipeline/trap controller.
// Interrupt-enable bit positions and the vectored-trap helpers live here.
package trap_ctrl_pkg;

    localparam int MSIP           = 3;
    localparam int MTIP           = 7;
    localparam int MEIP           = 11;
    localparam int LOCAL_IRQ_BASE = 16;

    // Bit 5 is the interrupt flag, so exception and interrupt codes never collide.
    typedef enum logic [5:0] {
        CAUSE_INSN_MISALIGN  = 6'h00,
        CAUSE_INSN_ACCESS    = 6'h01,
        CAUSE_ILLEGAL_INSN   = 6'h02,
        CAUSE_BREAKPOINT     = 6'h03,
        CAUSE_LOAD_MISALIGN  = 6'h04,
        CAUSE_LOAD_ACCESS    = 6'h05,
        CAUSE_STORE_MISALIGN = 6'h06,
        CAUSE_STORE_ACCESS   = 6'h07,
        CAUSE_ECALL_M        = 6'h0B,
        CAUSE_IRQ_MSI        = 6'h23,
        CAUSE_IRQ_MTI        = 6'h27,
        CAUSE_IRQ_MEI        = 6'h2B,
        CAUSE_IRQ_LOCAL0     = 6'h30
    } trap_cause_e;

    typedef enum logic [1:0] {
        MTVEC_DIRECT   = 2'd0,
        MTVEC_VECTORED = 2'd1
    } mtvec_mode_e;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ctrl_state_e;

    function automatic logic [31:0] irq_mask(input int num_local);
        logic [31:0] m;
        m       = 32'd0;
        m[MSIP] = 1'b1;
        m[MTIP] = 1'b1;
        m[MEIP] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i < num_local) m[LOCAL_IRQ_BASE + i] = 1'b1;
            else               m[LOCAL_IRQ_BASE + i] = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/trap_ctrl_irq_prio_enc.sv
// Machine interrupt priority encoder: MEI > MSI > MTI > local lines (lowest index first).
// The input is expected to be already masked to the implemented interrupt bits.
module irq_prio_enc
    import trap_ctrl_pkg::*;
#(
    parameter int NUM_LOCAL_IRQ = 16
) (
    input  logic [31:0] pend_i,
    output logic        valid_o,
    output logic [4:0]  code_o
);

    // Fixed-priority selection of the winning interrupt code.
    always_comb begin
        valid_o = |pend_i;
        code_o  = 5'd0;
        if (pend_i[MEIP]) begin
            code_o = 5'(MEIP);
        end else if (pend_i[MSIP]) begin
            code_o = 5'(MSIP);
        end else if (pend_i[MTIP]) begin
            code_o = 5'(MTIP);
        end else begin
            for (int i = 15; i >= 0; i--) begin
                code_o = ((i < NUM_LOCAL_IRQ) && pend_i[LOCAL_IRQ_BASE + i])
                         ? 5'(LOCAL_IRQ_BASE + i) : code_o;
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Fetch-PC / stall / flush controller with synchronous exceptions, machine interrupts
// and MRET; produces a registered trap record and commit pulses for the CSR file.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int          NUM_LOCAL_IRQ = 16,
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FLUSH_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        retire_valid_i,
    input  logic [31:0] retire_pc_i,
    input  logic        exc_valid_i,
    input  logic [4:0]  exc_code_i,
    input  logic [31:0] exc_tval_i,
    input  logic        mret_i,
    input  logic        branched_i,
    input  logic [31:0] new_pc_i,
    input  logic        stall_req_i,
    input  logic        mstatus_mie_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mip_i,
    input  logic [29:0] mtvec_base_i,
    input  logic [1:0]  mtvec_mode_i,
    input  logic [31:0] mepc_i,
    output logic [31:0] pc_o,
    output logic        fetch_stall_o,
    output logic        decode_stall_o,
    output logic        execute_stall_o,
    output logic        memory_stall_o,
    output logic        wb_stall_o,
    output logic        flush_o,
    output logic        trap_taken_o,
    output logic        mret_taken_o,
    output logic [31:0] trap_cause_o,
    output logic [31:0] trap_value_o,
    output logic [31:0] trap_epc_o
);

    localparam logic [31:0] IRQ_MASK  = irq_mask(NUM_LOCAL_IRQ);
    localparam logic [2:0]  FLUSH_TOP = 3'(FLUSH_CYCLES - 1);

    ctrl_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        trap_taken_q, trap_taken_d;
    logic        mret_taken_q, mret_taken_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] value_q, value_d;
    logic [31:0] epc_q, epc_d;

    logic [31:0] pend_s;
    logic        irq_valid_s;
    logic [4:0]  irq_code_s;
    logic [31:0] trap_base_s;
    logic [31:0] irq_target_s;

    assign pend_s = mie_i & mip_i & IRQ_MASK;

    irq_prio_enc #(
        .NUM_LOCAL_IRQ (NUM_LOCAL_IRQ)
    ) u_prio (
        .pend_i  (pend_s),
        .valid_o (irq_valid_s),
        .code_o  (irq_code_s)
    );

    assign trap_base_s  = {mtvec_base_i, 2'b00};
    assign irq_target_s = (mtvec_mode_i == MTVEC_VECTORED)
                          ? (trap_base_s + {25'd0, irq_code_s, 2'b00}) : trap_base_s;

    // Next-state: event priority in RUN, flush countdown in FLUSH.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_d         = pc_q;
        trap_taken_d = 1'b0;
        mret_taken_d = 1'b0;
        cause_d      = cause_q;
        value_d      = value_q;
        epc_d        = epc_q;
        case (state_q)
            RUN: begin
                if (stall_req_i) begin
                    pc_d = pc_q;
                end else if (exc_valid_i && retire_valid_i) begin
                    pc_d         = trap_base_s;
                    cause_d      = {27'd0, exc_code_i};
                    value_d      = exc_tval_i;
                    epc_d        = retire_pc_i;
                    trap_taken_d = 1'b1;
                    state_d      = FLUSH;
                    cnt_d        = FLUSH_TOP;
                end else if (mstatus_mie_i && retire_valid_i && irq_valid_s) begin
                    pc_d         = irq_target_s;
                    cause_d      = {1'b1, 26'd0, irq_code_s};
                    value_d      = 32'd0;
                    epc_d        = retire_pc_i;
                    trap_taken_d = 1'b1;
                    state_d      = FLUSH;
                    cnt_d        = FLUSH_TOP;
                end else if (mret_i && retire_valid_i) begin
                    pc_d         = mepc_i;
                    mret_taken_d = 1'b1;
                    state_d      = FLUSH;
                    cnt_d        = FLUSH_TOP;
                end else if (branched_i) begin
                    pc_d    = new_pc_i;
                    state_d = FLUSH;
                    cnt_d   = FLUSH_TOP;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
            FLUSH: begin
                if (cnt_q == 3'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Controller state, PC and trap record registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            cnt_q        <= 3'd0;
            pc_q         <= RESET_PC;
            trap_taken_q <= 1'b0;
            mret_taken_q <= 1'b0;
            cause_q      <= 32'd0;
            value_q      <= 32'd0;
            epc_q        <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pc_q         <= pc_d;
            trap_taken_q <= trap_taken_d;
            mret_taken_q <= mret_taken_d;
            cause_q      <= cause_d;
            value_q      <= value_d;
            epc_q        <= epc_d;
        end
    end

    // Memory waits must freeze the front of the pipe in the same cycle, so stalls follow stall_req_i directly.
    assign fetch_stall_o   = stall_req_i | (state_q == FLUSH);
    assign decode_stall_o  = stall_req_i;
    assign execute_stall_o = stall_req_i;
    assign memory_stall_o  = stall_req_i;
    assign wb_stall_o      = 1'b0;
    assign flush_o         = (state_q == FLUSH);
    assign pc_o            = pc_q;
    assign trap_taken_o    = trap_taken_q;
    assign mret_taken_o    = mret_taken_q;
    assign trap_cause_o    = cause_q;
    assign trap_value_o    = value_q;
    assign trap_epc_o      = epc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl; a second instance with four local lines
// shares the stimulus to check the parametrised interrupt mask.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        retire_valid_i, exc_valid_i, mret_i, branched_i, stall_req_i, mstatus_mie_i;
    logic [31:0] retire_pc_i, exc_tval_i, new_pc_i, mie_i, mip_i, mepc_i;
    logic [4:0]  exc_code_i;
    logic [29:0] mtvec_base_i;
    logic [1:0]  mtvec_mode_i;

    logic [31:0] pc_o, trap_cause_o, trap_value_o, trap_epc_o;
    logic        fetch_stall_o, decode_stall_o, execute_stall_o, memory_stall_o, wb_stall_o;
    logic        flush_o, trap_taken_o, mret_taken_o;

    logic [31:0] pc4_o, cause4_o, value4_o, epc4_o;
    logic        fs4_o, ds4_o, es4_o, ms4_o, ws4_o, flush4_o, trap4_o, mret4_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk(clk), .reset(reset), .retire_valid_i(retire_valid_i), .retire_pc_i(retire_pc_i),
        .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_tval_i(exc_tval_i),
        .mret_i(mret_i), .branched_i(branched_i), .new_pc_i(new_pc_i), .stall_req_i(stall_req_i),
        .mstatus_mie_i(mstatus_mie_i), .mie_i(mie_i), .mip_i(mip_i), .mtvec_base_i(mtvec_base_i),
        .mtvec_mode_i(mtvec_mode_i), .mepc_i(mepc_i), .pc_o(pc_o), .fetch_stall_o(fetch_stall_o),
        .decode_stall_o(decode_stall_o), .execute_stall_o(execute_stall_o),
        .memory_stall_o(memory_stall_o), .wb_stall_o(wb_stall_o), .flush_o(flush_o),
        .trap_taken_o(trap_taken_o), .mret_taken_o(mret_taken_o), .trap_cause_o(trap_cause_o),
        .trap_value_o(trap_value_o), .trap_epc_o(trap_epc_o)
    );

    trap_ctrl #(.NUM_LOCAL_IRQ(4)) dut4 (
        .clk(clk), .reset(reset), .retire_valid_i(retire_valid_i), .retire_pc_i(retire_pc_i),
        .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_tval_i(exc_tval_i),
        .mret_i(mret_i), .branched_i(branched_i), .new_pc_i(new_pc_i), .stall_req_i(stall_req_i),
        .mstatus_mie_i(mstatus_mie_i), .mie_i(mie_i), .mip_i(mip_i), .mtvec_base_i(mtvec_base_i),
        .mtvec_mode_i(mtvec_mode_i), .mepc_i(mepc_i), .pc_o(pc4_o), .fetch_stall_o(fs4_o),
        .decode_stall_o(ds4_o), .execute_stall_o(es4_o), .memory_stall_o(ms4_o),
        .wb_stall_o(ws4_o), .flush_o(flush4_o), .trap_taken_o(trap4_o), .mret_taken_o(mret4_o),
        .trap_cause_o(cause4_o), .trap_value_o(value4_o), .trap_epc_o(epc4_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        retire_valid_i = 1'b0; retire_pc_i = 32'd0; exc_valid_i = 1'b0; exc_code_i = 5'd0;
        exc_tval_i = 32'd0; mret_i = 1'b0; branched_i = 1'b0; new_pc_i = 32'd0;
        stall_req_i = 1'b0; mstatus_mie_i = 1'b0; mie_i = 32'd0; mip_i = 32'd0; mepc_i = 32'd0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        idle_inputs();
        mtvec_base_i = 30'h0000_0800; mtvec_mode_i = 2'd1;
        reset = 1'b0;
        #3;
        n_cmp++;
        if (pc_o !== 32'd0) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", pc_o, 32'd0); end
        n_cmp++;
        if ({fetch_stall_o, decode_stall_o, execute_stall_o, memory_stall_o, wb_stall_o,
             flush_o, trap_taken_o, mret_taken_o} !== 8'd0) begin
            n_err++; $display("FAIL reset_ctl got=%b exp=0", {fetch_stall_o, decode_stall_o,
                execute_stall_o, memory_stall_o, wb_stall_o, flush_o, trap_taken_o, mret_taken_o});
        end
        n_cmp++;
        if ({trap_cause_o, trap_value_o, trap_epc_o} !== 96'd0) begin
            n_err++; $display("FAIL reset_record got=%h/%h/%h exp=0", trap_cause_o, trap_value_o, trap_epc_o);
        end
        step();
        reset = 1'b1;
        exp_pc = 32'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_pc = exp_pc + 32'd4;
            n_cmp++;
            if (pc_o !== exp_pc || flush_o !== 1'b0 || fetch_stall_o !== 1'b0 || memory_stall_o !== 1'b0) begin
                n_err++; $display("FAIL run_pc got=%h fl=%b fs=%b exp=%h", pc_o, flush_o, fetch_stall_o, exp_pc);
            end
        end
    endtask

    task automatic test_irq_vectored();
        mtvec_base_i = 30'h0000_0800; mtvec_mode_i = 2'd1;
        mstatus_mie_i = 1'b1; retire_valid_i = 1'b1; retire_pc_i = 32'h40;
        mie_i = 32'h0000_0880; mip_i = 32'h0000_0880;
        step();
        n_cmp++;
        if (pc_o !== 32'h202C || trap_cause_o !== 32'h8000_000B || trap_epc_o !== 32'h40 ||
            trap_value_o !== 32'd0 || trap_taken_o !== 1'b1 || flush_o !== 1'b1 || fetch_stall_o !== 1'b1) begin
            n_err++; $display("FAIL irq_mei pc=%h cause=%h epc=%h val=%h tt=%b fl=%b exp pc=202c cause=8000000b epc=40",
                              pc_o, trap_cause_o, trap_epc_o, trap_value_o, trap_taken_o, flush_o);
        end
        idle_inputs();
        step();
        n_cmp++;
        if (trap_taken_o !== 1'b0 || flush_o !== 1'b1 || pc_o !== 32'h202C) begin
            n_err++; $display("FAIL irq_flush2 tt=%b fl=%b pc=%h exp tt=0 fl=1 pc=202c", trap_taken_o, flush_o, pc_o);
        end
        step();
        n_cmp++;
        if (flush_o !== 1'b0 || pc_o !== 32'h202C) begin
            n_err++; $display("FAIL irq_flush_end fl=%b pc=%h exp fl=0 pc=202c", flush_o, pc_o);
        end
        step();
        n_cmp++;
        if (pc_o !== 32'h2030) begin n_err++; $display("FAIL irq_resume got=%h exp=2030", pc_o); end
    endtask

    task automatic test_exc_priority();
        exc_valid_i = 1'b1; exc_code_i = 5'd2; exc_tval_i = 32'hDEAD_BEEF;
        retire_valid_i = 1'b1; retire_pc_i = 32'h100; mstatus_mie_i = 1'b1;
        mie_i = 32'h80; mip_i = 32'h80; branched_i = 1'b1; new_pc_i = 32'h5555_0000;
        step();
        n_cmp++;
        if (pc_o !== 32'h2000 || trap_cause_o !== 32'h2 || trap_value_o !== 32'hDEAD_BEEF ||
            trap_epc_o !== 32'h100 || trap_taken_o !== 1'b1) begin
            n_err++; $display("FAIL exc_prio pc=%h cause=%h val=%h epc=%h tt=%b exp pc=2000 cause=2 val=deadbeef epc=100",
                              pc_o, trap_cause_o, trap_value_o, trap_epc_o, trap_taken_o);
        end
        idle_inputs();
        step(); step(); step();
        n_cmp++;
        if (pc_o !== 32'h2004) begin n_err++; $display("FAIL exc_resume got=%h exp=2004", pc_o); end
    endtask

    task automatic test_local_irq();
        do_reset();
        mstatus_mie_i = 1'b1; retire_valid_i = 1'b1; retire_pc_i = 32'h80;
        mie_i = 32'h0020_0000; mip_i = 32'h0020_0000;
        step();
        n_cmp++;
        if (pc_o !== 32'h2054 || trap_cause_o !== 32'h8000_0015 || trap_taken_o !== 1'b1 || trap_epc_o !== 32'h80) begin
            n_err++; $display("FAIL local21 pc=%h cause=%h tt=%b epc=%h exp pc=2054 cause=80000015 tt=1 epc=80",
                              pc_o, trap_cause_o, trap_taken_o, trap_epc_o);
        end
        n_cmp++;
        if (pc4_o !== 32'h4 || trap4_o !== 1'b0 || flush4_o !== 1'b0) begin
            n_err++; $display("FAIL local21_n4 pc=%h tt=%b fl=%b exp pc=4 tt=0 fl=0", pc4_o, trap4_o, flush4_o);
        end
        idle_inputs();
        step(); step();
        n_cmp++;
        if (pc_o !== 32'h2054 || flush_o !== 1'b0) begin
            n_err++; $display("FAIL local_flush_end pc=%h fl=%b exp pc=2054 fl=0", pc_o, flush_o);
        end
    endtask

    task automatic test_mret();
        mret_i = 1'b1; retire_valid_i = 1'b1; retire_pc_i = 32'h2054; mepc_i = 32'h300;
        step();
        n_cmp++;
        if (pc_o !== 32'h300 || mret_taken_o !== 1'b1 || trap_taken_o !== 1'b0 || flush_o !== 1'b1) begin
            n_err++; $display("FAIL mret pc=%h mt=%b tt=%b fl=%b exp pc=300 mt=1 tt=0 fl=1",
                              pc_o, mret_taken_o, trap_taken_o, flush_o);
        end
        mret_i = 1'b0; exc_valid_i = 1'b1; exc_code_i = 5'd2; exc_tval_i = 32'h1234_5678;
        step();
        step();
        n_cmp++;
        if (pc_o !== 32'h300 || trap_taken_o !== 1'b0 || mret_taken_o !== 1'b0 || trap_cause_o !== 32'h8000_0015) begin
            n_err++; $display("FAIL flush_ignore pc=%h tt=%b mt=%b cause=%h exp pc=300 tt=0 mt=0 cause=80000015",
                              pc_o, trap_taken_o, mret_taken_o, trap_cause_o);
        end
        idle_inputs();
        step();
        n_cmp++;
        if (pc_o !== 32'h304 || trap_taken_o !== 1'b0) begin
            n_err++; $display("FAIL mret_resume pc=%h tt=%b exp pc=304 tt=0", pc_o, trap_taken_o);
        end
    endtask

    task automatic test_stall_irq();
        mtvec_mode_i = 2'd0; mstatus_mie_i = 1'b1; retire_valid_i = 1'b1; retire_pc_i = 32'h304;
        mie_i = 32'h8; mip_i = 32'h8; stall_req_i = 1'b1;
        #1;
        n_cmp++;
        if ({fetch_stall_o, decode_stall_o, execute_stall_o, memory_stall_o, wb_stall_o} !== 5'b11110) begin
            n_err++; $display("FAIL stall_outs got=%b exp=11110", {fetch_stall_o, decode_stall_o,
                              execute_stall_o, memory_stall_o, wb_stall_o});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (pc_o !== 32'h304 || trap_taken_o !== 1'b0 || flush_o !== 1'b0 || wb_stall_o !== 1'b0) begin
                n_err++; $display("FAIL stall_hold pc=%h tt=%b fl=%b wb=%b exp pc=304 tt=0 fl=0 wb=0",
                                  pc_o, trap_taken_o, flush_o, wb_stall_o);
            end
        end
        stall_req_i = 1'b0;
        step();
        n_cmp++;
        if (pc_o !== 32'h2000 || trap_cause_o !== 32'h8000_0003 || trap_epc_o !== 32'h304 || trap_taken_o !== 1'b1) begin
            n_err++; $display("FAIL stall_release pc=%h cause=%h epc=%h tt=%b exp pc=2000 cause=80000003 epc=304 tt=1",
                              pc_o, trap_cause_o, trap_epc_o, trap_taken_o);
        end
        idle_inputs();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (pc_o !== 32'd0 || flush_o !== 1'b0 || trap_taken_o !== 1'b0 || trap_cause_o !== 32'd0) begin
            n_err++; $display("FAIL reset_mid_flush pc=%h fl=%b tt=%b cause=%h exp all 0",
                              pc_o, flush_o, trap_taken_o, trap_cause_o);
        end
        step();
        reset = 1'b1;
    endtask

    task automatic test_branch_wrap();
        branched_i = 1'b1; new_pc_i = 32'hFFFF_FFFC;
        step();
        n_cmp++;
        if (pc_o !== 32'hFFFF_FFFC || flush_o !== 1'b1 || trap_taken_o !== 1'b0 || mret_taken_o !== 1'b0) begin
            n_err++; $display("FAIL branch pc=%h fl=%b tt=%b mt=%b exp pc=fffffffc fl=1 tt=0 mt=0",
                              pc_o, flush_o, trap_taken_o, mret_taken_o);
        end
        idle_inputs();
        step(); step(); step();
        n_cmp++;
        if (pc_o !== 32'd0) begin n_err++; $display("FAIL pc_wrap got=%h exp=0", pc_o); end
    endtask

    initial begin
        test_reset();
        test_irq_vectored();
        test_exc_priority();
        test_local_irq();
        test_mret();
        test_stall_irq();
        test_branch_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
